// File: rtl/mul_share_arb_pkg.sv
// Shared float16 result-class encodings and the tagged result record.
// The multiplier reports its class one-hot: [3:0] special, [4] subnormal,
// [5] normal. The arbiter stores results without interpreting them.
package fp16_mac_pkg;
  localparam logic [5:0] PT_NORM = 6'b100000;
  localparam logic [5:0] PT_SUB  = 6'b010000;
  localparam logic [5:0] PT_ZERO = 6'b000001;
  localparam logic [5:0] PT_INF  = 6'b000010;
  localparam logic [5:0] PT_NAN  = 6'b000100;
  localparam logic [5:0] PT_SPC3 = 6'b001000;
  localparam int         RES_W   = 22;

  typedef struct packed {
    logic [5:0]  ptype;
    logic [15:0] p;
  } fp16_res_t;
endpackage

// File: rtl/mul_share_arb_if.sv
// Bundle of request, multiplier and result-port signals for mul_share_arb.
//   slave  : the arbiter side (takes requests/products, drives grants/results)
//   master : the environment side (requesters, multiplier, consumers)
interface mul_share_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       REQ_V;
  logic [N_REQ-1:0][15:0] REQ_A;
  logic [N_REQ-1:0][15:0] REQ_B;
  logic [N_REQ-1:0]       REQ_RDY;
  logic                   MUL_V;
  logic [15:0]            MUL_A;
  logic [15:0]            MUL_B;
  logic [5:0]             MUL_P_TYPE;
  logic [15:0]            MUL_P;
  logic [N_REQ-1:0]       RES_V;
  logic [N_REQ-1:0][15:0] RES_P;
  logic [N_REQ-1:0][5:0]  RES_TYPE;
  logic [N_REQ-1:0]       RES_RDY;

  modport slave (
    input  REQ_V, REQ_A, REQ_B, MUL_P_TYPE, MUL_P, RES_RDY,
    output REQ_RDY, MUL_V, MUL_A, MUL_B, RES_V, RES_P, RES_TYPE
  );
  modport master (
    output REQ_V, REQ_A, REQ_B, MUL_P_TYPE, MUL_P, RES_RDY,
    input  REQ_RDY, MUL_V, MUL_A, MUL_B, RES_V, RES_P, RES_TYPE
  );
endinterface

// File: rtl/mul_share_arb_res_fifo.sv
// Per-requester result FIFO: circular buffer, wrap-around pointers and an
// occupancy count. No bypass: a push into an empty FIFO shows next cycle.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write a result record
//   pop        : consume the head (ignored when empty)
//   vld, dout  : head valid / head record (reads 0 when empty)
module res_fifo
  import fp16_mac_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  fp16_res_t din,
  input  logic      pop,
  output logic      vld,
  output fp16_res_t dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fp16_res_t       mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            do_pop;

  assign do_pop = pop && (cnt != '0);
  assign vld    = (cnt != '0);
  assign dout   = vld ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)   wp <= (int'(wp) == DEPTH-1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= (int'(rp) == DEPTH-1) ? '0 : rp + 1'b1;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Credits reserve a slot for every in-flight result, so this cannot fire.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (int'(cnt) == DEPTH)));
endmodule

// File: rtl/mul_share_arb.sv
// Round-robin share of one pipelined fp16 multiplier among N_REQ requesters.
// A winner's operands are registered into the issue stage together with a
// tag; the tag rides a fixed-latency pipe and steers the returning product
// into that requester's result FIFO. Grants are gated by per-requester
// credits equal to free FIFO slots, so a stalled consumer only blocks itself.
//   CLK, RSTn : clock, async active-low reset
//   bus       : request / multiplier / result signals (slave side)
module mul_share_arb
  import fp16_mac_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = MUL_LAT + 2
) (
  input  logic            CLK,
  input  logic            RSTn,
  mul_share_arb_if.slave  bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CRW = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0]              rr;
  logic [N_REQ-1:0][CRW-1:0]   credit;
  logic [N_REQ-1:0]            elig, gnt, pop, res_v;
  logic                        gnt_any;
  logic [IDW-1:0]              gnt_id;
  int                          idx;
  // [0] is the issue stage (aligned with MUL_V); [MUL_LAT] aligns with MUL_P.
  logic [MUL_LAT:0]            tag_v;
  logic [MUL_LAT:0][IDW-1:0]   tag_id;
  fp16_res_t                   cap;
  fp16_res_t                   res_head [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) elig[i] = bus.REQ_V[i] && (credit[i] != '0);
  end

  // First eligible index at or after rr, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr) + k) % N_REQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign bus.REQ_RDY = gnt;
  assign pop         = res_v & bus.RES_RDY;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rr        <= '0;
      bus.MUL_V <= 1'b0;
      bus.MUL_A <= '0;
      bus.MUL_B <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
    end else begin
      bus.MUL_V <= gnt_any;
      if (gnt_any) begin
        bus.MUL_A <= bus.REQ_A[gnt_id];
        bus.MUL_B <= bus.REQ_B[gnt_id];
        rr        <= (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
      end
      tag_v  <= {tag_v[MUL_LAT-1:0], gnt_any};
      tag_id <= {tag_id[MUL_LAT-1:0], gnt_id};
    end
  end

  // A credit is a FIFO slot not yet claimed by an in-flight or stored result.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < N_REQ; i++) credit[i] <= CRW'(FIFO_DEPTH);
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        case ({gnt[i], pop[i]})
          2'b10:   credit[i] <= credit[i] - 1'b1;
          2'b01:   credit[i] <= credit[i] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign cap.ptype = bus.MUL_P_TYPE;
  assign cap.p     = bus.MUL_P;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (RSTn),
      .push  (tag_v[MUL_LAT] && (tag_id[MUL_LAT] == IDW'(g))),
      .din   (cap),
      .pop   (bus.RES_RDY[g]),
      .vld   (res_v[g]),
      .dout  (res_head[g])
    );
  end

  assign bus.RES_V = res_v;
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      bus.RES_P[i]    = res_head[i].p;
      bus.RES_TYPE[i] = res_head[i].ptype;
    end
  end

  a_credit_max: assert property (@(posedge CLK) disable iff (!RSTn)
    !(gnt_any && (credit[gnt_id] == '0)));
endmodule
